// File: rtl/fp_add_rr_arbiter.sv
// Round-robin arbiter that time-shares one combinational fp32 adder among N_REQ requesters.
// Holds one operation at a time (IDLE -> EXEC -> DONE) and keeps the registered result until it is taken.

module fp32_add_core (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_sum
);
   logic [31:0] w_l, w_s;
   logic [7:0]  w_el, w_es, w_d;
   logic [26:0] w_ml, w_ms;
   logic [27:0] w_acc;
   logic [9:0]  w_e;
   logic [24:0] w_m;
   logic        w_st, w_inc, w_sign, w_nan, w_special;

   always_comb begin
      w_l  = (i_b[30:0] > i_a[30:0]) ? i_b : i_a;
      w_s  = (i_b[30:0] > i_a[30:0]) ? i_a : i_b;
      w_el = (w_l[30:23] == 8'd0) ? 8'd1 : w_l[30:23];
      w_es = (w_s[30:23] == 8'd0) ? 8'd1 : w_s[30:23];
      w_d  = w_el - w_es;
      w_ml = {(w_l[30:23] != 8'd0), w_l[22:0], 3'b000};
      w_ms = {(w_s[30:23] != 8'd0), w_s[22:0], 3'b000};
      // Bits shifted out of the smaller operand collapse into the sticky bit.
      w_st = 1'b0;
      for (int k = 0; k < 27; k++)
         if (k < int'(w_d) && w_ms[k]) w_st = 1'b1;
      w_ms    = (w_d > 8'd26) ? 27'd0 : (w_ms >> w_d);
      w_ms[0] = w_ms[0] | w_st;
      w_acc = (w_l[31] == w_s[31]) ? ({1'b0, w_ml} + {1'b0, w_ms})
                                   : ({1'b0, w_ml} - {1'b0, w_ms});
      w_e = {2'b00, w_el};
      if (w_acc[27]) begin
         w_acc = {1'b0, w_acc[27:2], w_acc[1] | w_acc[0]};
         w_e   = w_e + 10'd1;
      end
      for (int k = 0; k < 26; k++)
         if (!w_acc[26] && w_e > 10'd1) begin
            w_acc = w_acc << 1;
            w_e   = w_e - 10'd1;
         end
      w_sign = (w_acc == 28'd0 && w_l[31] != w_s[31]) ? 1'b0 : w_l[31];
      w_inc  = w_acc[2] & (w_acc[1] | w_acc[0] | w_acc[3]);
      w_m    = {1'b0, w_acc[26:3]} + {24'd0, w_inc};
      if (w_m[24]) begin
         w_m = w_m >> 1;
         w_e = w_e + 10'd1;
      end
      w_special = (w_l[30:23] == 8'hFF);
      w_nan = (w_l[30:23] == 8'hFF && w_l[22:0] != 23'd0) ||
              (w_s[30:23] == 8'hFF && w_s[22:0] != 23'd0) ||
              (w_s[30:23] == 8'hFF && w_l[31] != w_s[31]);
      if (w_nan)               o_sum = 32'h7FC0_0000;
      else if (w_special)      o_sum = {w_l[31], 8'hFF, 23'd0};
      else if (w_e >= 10'd255) o_sum = {w_sign, 8'hFF, 23'd0};
      else                     o_sum = {w_sign, (w_m[23] ? w_e[7:0] : 8'd0), w_m[22:0]};
   end
endmodule

module fp_add_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [32*N_REQ-1:0]  i_req_a,
   input  logic [32*N_REQ-1:0]  i_req_b,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic [31:0]          o_res_sum,
   output logic [ID_W-1:0]      o_res_id,
   output logic                 o_busy,
   output logic [15:0]          o_op_count,
   output logic [1:0]           o_dbg_state
);
   // Handshakes: a request transfers when req_valid[i] && req_ready[i] at a rising edge;
   // the result transfers when res_valid && res_ready at a rising edge.
   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

   state_t          r_state, w_next;
   logic [PW-1:0]   r_last, r_id, w_g;
   logic [PW:0]     w_idx;
   logic            w_found;
   logic [31:0]     r_a, r_b, r_sum, w_core, w_sel;
   logic            r_valid;
   logic [ID_W-1:0] r_res_id;
   logic [15:0]     r_ops;
   logic [31:0]     w_a_arr [N_REQ];
   logic [31:0]     w_b_arr [N_REQ];

   fp32_add_core u_core (.i_a(r_a), .i_b(r_b), .o_sum(w_core));

   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         w_a_arr[k] = i_req_a[32*k +: 32];
         w_b_arr[k] = i_req_b[32*k +: 32];
      end
   end

   // Search starts one past the last winner and wraps modulo N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_g     = '0;
      w_idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = {1'b0, r_last} + (PW+1)'(k);
         if (w_idx >= (PW+1)'(N_REQ)) w_idx = w_idx - (PW+1)'(N_REQ);
         if (!w_found && i_req_valid[w_idx[PW-1:0]]) begin
            w_found = 1'b1;
            w_g     = w_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      w_next      = r_state;
      o_req_ready = '0;
      case (r_state)
         S_IDLE: if (w_found) begin
            o_req_ready[w_g] = 1'b1;
            w_next           = S_EXEC;
         end
         S_EXEC:  w_next = S_DONE;
         S_DONE:  if (i_res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // A zero operand (either sign) passes the other operand through untouched.
   always_comb begin
      if (r_a[30:0] == 31'd0)      w_sel = r_b;
      else if (r_b[30:0] == 31'd0) w_sel = r_a;
      else                         w_sel = w_core;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_last   <= PW'(N_REQ - 1);
         r_id     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_sum    <= '0;
         r_valid  <= 1'b0;
         r_res_id <= '0;
         r_ops    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (w_found) begin
               r_a    <= w_a_arr[w_g];
               r_b    <= w_b_arr[w_g];
               r_id   <= w_g;
               r_last <= w_g;
            end
            S_EXEC: begin
               r_sum    <= w_sel;
               r_res_id <= ID_W'(r_id);
               r_valid  <= 1'b1;
            end
            S_DONE: if (i_res_ready) begin
               r_valid <= 1'b0;
               r_ops   <= r_ops + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign o_res_valid = r_valid;
   assign o_res_sum   = r_sum;
   assign o_res_id    = r_res_id;
   assign o_busy      = (r_state != S_IDLE);
   assign o_op_count  = r_ops;
   assign o_dbg_state = r_state;
endmodule
